counter_mod_updown: RTL and testbench

//  Parametrised successor to the plain enable counter. Adds:
//   - modulo-M counting in either direction
//   - wrap or saturate at the limits
//   - synchronous clear and parallel load
//   - built-in clock-enable prescaler
//   - cascade carry for chaining stages

---
 rtl/counter_mod_updown_pkg.sv | 23 ++
 rtl/counter_mod_updown_if.sv | 26 ++
 rtl/counter_mod_updown_tick_prescaler.sv | 45 ++++
 rtl/counter_mod_updown.sv | 99 +++++++++
 tb/tb_counter_mod_updown.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_mod_updown_pkg.sv
// Shared constants and elaboration helpers for the modulo up/down counter.
package counter_mod_updown_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Ceiling log2; clog2(1) is 0, so callers needing a register width clamp to 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/counter_mod_updown_if.sv
// Control and status bundle of one counter stage; the stage itself takes the slave side.
interface counter_mod_updown_if #(
    parameter int N = 8
);

    logic         en;
    logic         dir;
    logic         clr;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] q;
    logic         tc;
    logic         co;
    logic         wrapped;

    modport master (
        output en, dir, clr, load, load_val,
        input  q, tc, co, wrapped
    );

    modport slave (
        input  en, dir, clr, load, load_val,
        output q, tc, co, wrapped
    );

endinterface

// File: rtl/counter_mod_updown_tick_prescaler.sv
// Clock-enable divider: step pulses on every PRESCALE-th enabled cycle; combinational step.
module counter_mod_updown_tick_prescaler
    import counter_mod_updown_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic step
);

    localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PW-1:0] LAST_PHASE = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_mod_updown_tick_prescaler: PRESCALE must be >= 1");
    end

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    assign step = en && (phase_q == LAST_PHASE);

    // restart realigns the divider with a cleared or freshly loaded count
    always_comb begin
        phase_d = phase_q;
        if (restart) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = step ? '0 : phase_q + PHASE_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/counter_mod_updown.sv
// Modulo-MODULO up/down counter with wrap/saturate, clear, load, prescaler and cascade carry.
// q updates on the edge sampling step; tc/co are combinational so a chained stage steps on the same edge.
module counter_mod_updown
    import counter_mod_updown_pkg::*;
#(
    parameter int N        = 8,
    parameter int MODULO   = 256,
    parameter int PRESCALE = 1,
    parameter int SAT      = MODE_WRAP
) (
    input  logic clk,
    input  logic rst,
    counter_mod_updown_if.slave bus
);

    if (N < 1 || N > 30) begin : g_bad_width
        $error("counter_mod_updown: N must be in 1..30");
    end
    if (MODULO < 2 || MODULO > (1 << N)) begin : g_bad_modulo
        $error("counter_mod_updown: MODULO must satisfy 2 <= MODULO <= 2**N");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_mod_updown: PRESCALE must be >= 1");
    end
    if (SAT != MODE_WRAP && SAT != MODE_SAT) begin : g_bad_sat
        $error("counter_mod_updown: SAT must be 0 (wrap) or 1 (saturate)");
    end

    // Compares and arithmetic run one bit wider so MODULO == 2**N needs no special case.
    localparam logic [N:0] LAST_EXT = (N + 1)'(MODULO - 1);
    localparam logic [N:0] ONE_EXT  = (N + 1)'(1);
    localparam logic [N-1:0] LAST   = LAST_EXT[N-1:0];

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;
    logic         wrapped_q;
    logic         wrapped_d;
    logic         step;
    logic         restart;
    logic         up;
    logic         at_max;
    logic         at_zero;
    logic         tc;

    assign up      = (bus.dir == DIR_UP);
    assign at_max  = ({1'b0, q_q} == LAST_EXT);
    assign at_zero = (q_q == '0);
    assign tc      = up ? at_max : at_zero;
    assign restart = bus.clr | bus.load;

    counter_mod_updown_tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.en),
        .restart (restart),
        .step    (step)
    );

    always_comb begin
        q_d       = q_q;
        wrapped_d = wrapped_q;
        if (bus.clr) begin
            q_d       = '0;
            wrapped_d = 1'b0;
        end else if (bus.load) begin
            q_d = ({1'b0, bus.load_val} > LAST_EXT) ? LAST : bus.load_val;
        end else if (step) begin
            if (tc) begin
                wrapped_d = 1'b1;
                if (SAT == MODE_WRAP) begin
                    q_d = up ? '0 : LAST;
                end
            end else if (up) begin
                q_d = N'({1'b0, q_q} + ONE_EXT);
            end else begin
                q_d = N'({1'b0, q_q} - ONE_EXT);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= '0;
            wrapped_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.tc      = tc;
    // Gated by rst so a downstream stage never sees a carry while this one is held in reset.
    assign bus.co      = step & tc & ~rst;
    assign bus.wrapped = wrapped_q;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Five counter stages (wrap, saturate+prescale, full 2**N range, two-stage cascade)
// checked every cycle against an arithmetic reference model plus hand-computed expectations.
module tb_counter_mod_updown;

    localparam int NS = 5;
    // slot: 0 wrap/P1, 1 sat/P3, 2 full-range/P2, 3 cascade low, 4 cascade high
    localparam int MOD_T [NS] = '{10, 10, 16, 10, 10};
    localparam int PRE_T [NS] = '{1, 3, 2, 1, 1};
    localparam int SAT_T [NS] = '{0, 1, 0, 0, 0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_en   [NS];
    logic       in_dir  [NS];
    logic       in_clr  [NS];
    logic       in_load [NS];
    logic [3:0] in_lv   [NS];

    logic [3:0] out_q  [NS];
    logic       out_tc [NS];
    logic       out_co [NS];
    logic       out_w  [NS];

    counter_mod_updown_if #(.N(4)) ifs [NS] ();

    for (genvar g = 0; g < NS; g++) begin : g_dut
        if (g == 4) begin : g_chain
            assign ifs[g].en = ifs[3].co;
        end else begin : g_free
            assign ifs[g].en = in_en[g];
        end
        assign ifs[g].dir      = in_dir[g];
        assign ifs[g].clr      = in_clr[g];
        assign ifs[g].load     = in_load[g];
        assign ifs[g].load_val = in_lv[g];
        assign out_q[g]        = ifs[g].q;
        assign out_tc[g]       = ifs[g].tc;
        assign out_co[g]       = ifs[g].co;
        assign out_w[g]        = ifs[g].wrapped;

        counter_mod_updown #(
            .N        (4),
            .MODULO   (MOD_T[g]),
            .PRESCALE (PRE_T[g]),
            .SAT      (SAT_T[g])
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (ifs[g])
        );
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference state: count value, number of enabled cycles since last restart, sticky flag.
    int m_q  [NS];
    int m_ph [NS];
    bit m_w  [NS];

    function automatic bit m_tc(input int s);
        return in_dir[s] ? (m_q[s] == MOD_T[s] - 1) : (m_q[s] == 0);
    endfunction

    function automatic bit m_lo_co();
        return !rst && in_en[3] && (m_ph[3] == PRE_T[3] - 1) && m_tc(3);
    endfunction

    function automatic bit m_en(input int s);
        return (s == 4) ? m_lo_co() : bit'(in_en[s]);
    endfunction

    function automatic bit m_co(input int s);
        return !rst && m_en(s) && (m_ph[s] == PRE_T[s] - 1) && m_tc(s);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_q[s]  = 0;
            m_ph[s] = 0;
            m_w[s]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit en_s [NS];
        for (int s = 0; s < NS; s++) en_s[s] = m_en(s);
        for (int s = 0; s < NS; s++) begin
            if (rst) begin
                m_q[s] = 0; m_ph[s] = 0; m_w[s] = 1'b0;
            end else if (in_clr[s]) begin
                m_q[s] = 0; m_ph[s] = 0; m_w[s] = 1'b0;
            end else if (in_load[s]) begin
                m_q[s]  = (int'(in_lv[s]) > MOD_T[s] - 1) ? MOD_T[s] - 1 : int'(in_lv[s]);
                m_ph[s] = 0;
            end else if (en_s[s]) begin
                if (m_ph[s] < PRE_T[s] - 1) begin
                    m_ph[s] = m_ph[s] + 1;
                end else begin
                    m_ph[s] = 0;
                    if (in_dir[s]) begin
                        if (m_q[s] == MOD_T[s] - 1) begin
                            m_w[s] = 1'b1;
                            if (SAT_T[s] == 0) m_q[s] = 0;
                        end else begin
                            m_q[s] = m_q[s] + 1;
                        end
                    end else begin
                        if (m_q[s] == 0) begin
                            m_w[s] = 1'b1;
                            if (SAT_T[s] == 0) m_q[s] = MOD_T[s] - 1;
                        end else begin
                            m_q[s] = m_q[s] - 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input int s, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s slot%0d: got %0d, expected %0d at %0t", name, s, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int s = 0; s < NS; s++) begin
            check("q",       s, int'(out_q[s]),  m_q[s]);
            check("tc",      s, int'(out_tc[s]), int'(m_tc(s)));
            check("co",      s, int'(out_co[s]), int'(m_co(s)));
            check("wrapped", s, int'(out_w[s]),  int'(m_w[s]));
        end
    endtask

    // Entered just after a falling edge with inputs already applied.
    task automatic tick();
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        for (int s = 0; s < NS; s++) begin
            in_en[s]   = 1'b0;
            in_clr[s]  = 1'b0;
            in_load[s] = 1'b0;
            in_lv[s]   = 4'd0;
        end
    endtask

    int t1_seq [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
    int t2_seq [3]  = '{0, 9, 8};
    bit t3_pat [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        idle();
        for (int s = 0; s < NS; s++) in_dir[s] = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_all();
        check("rst_q", 0, int'(out_q[0]), 0);
        check("rst_w", 0, int'(out_w[0]), 0);
        rst = 1'b0;
        @(negedge clk);

        // Plain wrap-around up count
        in_en[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            check("t1_q",    0, int'(out_q[0]), t1_seq[i]);
            check("t1_co",   0, int'(out_co[0]), int'(i == 9));
            check("t1_wrap", 0, int'(out_w[0]), int'(i >= 10));
            tick();
        end

        // Clear, then count down through zero; slot 1 saturates at zero
        idle();
        in_clr[0] = 1'b1;
        tick();
        check("t2_clr_q", 0, int'(out_q[0]), 0);
        check("t2_clr_w", 0, int'(out_w[0]), 0);
        idle();
        in_en[0] = 1'b1; in_dir[0] = 1'b0;
        in_en[1] = 1'b1; in_dir[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("t2_down_q", 0, int'(out_q[0]), t2_seq[i]);
            tick();
        end
        check("t2_sat_q",  1, int'(out_q[1]),  0);
        check("t2_sat_tc", 1, int'(out_tc[1]), 1);
        check("t2_sat_w",  1, int'(out_w[1]),  1);

        // Prescale 3 with a gap in enable
        idle();
        in_clr[1] = 1'b1; in_dir[1] = 1'b1;
        tick();
        in_clr[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_en[1] = t3_pat[i];
            tick();
            if (i == 2) check("t3_hold", 1, int'(out_q[1]), 0);
        end
        check("t3_step", 1, int'(out_q[1]), 1);

        // Load clamps to MODULO-1 and beats a concurrent step
        idle();
        in_load[0] = 1'b1; in_lv[0] = 4'd15;
        tick();
        check("t4_clamp", 0, int'(out_q[0]), 9);
        in_lv[0] = 4'd5; in_en[0] = 1'b1; in_dir[0] = 1'b1;
        tick();
        check("t4_load_vs_step", 0, int'(out_q[0]), 5);

        // Two-stage decimal cascade
        idle();
        in_clr[3] = 1'b1; in_clr[4] = 1'b1;
        tick();
        idle();
        in_dir[3] = 1'b1; in_dir[4] = 1'b1; in_en[3] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1 check("t5_cascade", 3, int'(out_q[4]) * 10 + int'(out_q[3]), i);
            tick();
        end
        check("t5_roll_lo", 3, int'(out_q[3]), 0);
        check("t5_roll_hi", 4, int'(out_q[4]), 0);

        // Asynchronous reset mid-prescale
        idle();
        in_load[1] = 1'b1; in_lv[1] = 4'd7;
        tick();
        idle();
        in_en[1] = 1'b1; in_dir[1] = 1'b1;
        in_en[0] = 1'b1; in_dir[0] = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        check("t6_q", 1, int'(out_q[1]), 0);
        check("t6_w", 0, int'(out_w[0]), 0);
        for (int s = 0; s < NS; s++) check("t6_co", s, int'(out_co[s]), 0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("t6_hold", 1, int'(out_q[1]), 0);
        tick();
        check("t6_first", 1, int'(out_q[1]), 1);

        // Random traffic on every stage
        for (int it = 0; it < 1500; it++) begin
            for (int s = 0; s < NS; s++) begin
                in_en[s]   = ($urandom_range(3) != 0);
                if ($urandom_range(7) == 0) in_dir[s] = ~in_dir[s];
                in_clr[s]  = ($urandom_range(31) == 0);
                in_load[s] = ($urandom_range(15) == 0);
                in_lv[s]   = 4'($urandom_range(15));
            end
            if ($urandom_range(199) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
